// File: rtl/game_pkg.sv
// Shared types and default constants for the game state manager.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    HIT       = 3'd2,
    GAME_OVER = 3'd3,
    WIN       = 3'd4
  } game_state_t;

  localparam int LIVES_W = 3;
  localparam int TIMER_W = 9;

  localparam int DEF_START_LIVES   = 3;
  localparam int DEF_ALIEN_POINTS  = 10;
  localparam int DEF_SCORE_W       = 16;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_GOD_FRAMES    = 300;
  localparam int DEF_TURBO_FRAMES  = 300;
  localparam int DEF_BLINK_SHIFT   = 2;

  // One sticky bit per raw collision strobe, held until the next frame boundary.
  typedef struct packed {
    logic       god;
    logic       turbo;
    logic       border;
    logic [1:0] alien;
    logic       hRocket;
    logic [2:0] rocket;
    logic       alienPulse;
  } event_latch_t;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; clear beats load, load beats a tick.
module frame_timer
  import game_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] loadValue,
  output logic         active
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = loadValue;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign active = |count_q;

endmodule

// File: rtl/game_state_manager.sv
// Turns per-pixel collision strobes into frame-aligned game events:
// lives, score, power-up timers and the overall game state.
module game_state_manager
  import game_pkg::*;
#(
  parameter int START_LIVES   = DEF_START_LIVES,
  parameter int ALIEN_POINTS  = DEF_ALIEN_POINTS,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int GOD_FRAMES    = DEF_GOD_FRAMES,
  parameter int TURBO_FRAMES  = DEF_TURBO_FRAMES,
  parameter int BLINK_SHIFT   = DEF_BLINK_SHIFT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_game,
  input  logic               playerHitByAlienPulse,
  input  logic [2:0]         playerHitByRocket,
  input  logic               PlayerHitBy_h_Rocket,
  input  logic [1:0]         alienHit,
  input  logic               aliensReachedBorder,
  input  logic               TurboCollision,
  input  logic               GodModeCollision,
  input  logic               aliens_cleared,
  output logic [2:0]         game_state,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               player_hit_pulse,
  output logic               alien_kill_pulse,
  output logic               god_active,
  output logic               turbo_active,
  output logic               player_visible
);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         frameCnt_q;
  logic               hitPulse_q, hitPulse_d;
  logic               killPulse_q, killPulse_d;
  event_latch_t       raw, latch_q, latch_d;

  logic        playerHit, inGame, hitActive;
  logic [1:0]  killCount;
  logic [31:0] addVal, headroom;
  logic        timersClear, hitLoad, hitTick, frameTick;

  assign raw = event_latch_t'({GodModeCollision, TurboCollision, aliensReachedBorder,
                               alienHit, PlayerHitBy_h_Rocket, playerHitByRocket,
                               playerHitByAlienPulse});

  // Reload rather than clear on the frame strobe so same-cycle events land in the next frame.
  assign latch_d = startOfFrame ? raw : event_latch_t'(latch_q | raw);

  assign playerHit = latch_q.alienPulse | (|latch_q.rocket) | latch_q.hRocket;
  assign killCount = {1'b0, latch_q.alien[1]} + {1'b0, latch_q.alien[0]};
  assign inGame    = (state_q == PLAY) || (state_q == HIT);
  assign frameTick = startOfFrame && inGame;
  assign hitTick   = startOfFrame && (state_q == HIT);
  assign addVal    = 32'(killCount) * 32'(ALIEN_POINTS);
  assign headroom  = 32'({SCORE_W{1'b1}} - score_q);

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    hitPulse_d  = 1'b0;
    killPulse_d = 1'b0;
    timersClear = 1'b0;
    hitLoad     = 1'b0;

    unique case (state_q)
      IDLE, GAME_OVER, WIN: begin
        if (start_game) begin
          state_d     = PLAY;
          lives_d     = LIVES_W'(START_LIVES);
          score_d     = '0;
          timersClear = 1'b1;
        end
      end
      PLAY: begin
        if (startOfFrame) begin
          if (latch_q.border) begin
            state_d = GAME_OVER;
          end else if (playerHit && !god_active) begin
            lives_d    = lives_q - LIVES_W'(1);
            hitPulse_d = 1'b1;
            if (lives_q == LIVES_W'(1)) begin
              state_d = GAME_OVER;
            end else begin
              state_d = HIT;
              hitLoad = 1'b1;
            end
          end else if (aliens_cleared) begin
            state_d = WIN;
          end
        end
      end
      HIT: begin
        if (startOfFrame && latch_q.border) begin
          state_d = GAME_OVER;
        end else if (startOfFrame && aliens_cleared) begin
          state_d = WIN;
        end else if (!hitActive) begin
          state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    // Kills still score on the frame that ends the game.
    if (frameTick) begin
      killPulse_d = (killCount != 2'd0);
      if (addVal > headroom) begin
        score_d = '1;
      end else begin
        score_d = score_q + SCORE_W'(addVal);
      end
    end

    if (inGame && ((state_d == GAME_OVER) || (state_d == WIN))) begin
      timersClear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      frameCnt_q  <= '0;
      hitPulse_q  <= 1'b0;
      killPulse_q <= 1'b0;
      latch_q     <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      frameCnt_q  <= startOfFrame ? frameCnt_q + 8'd1 : frameCnt_q;
      hitPulse_q  <= hitPulse_d;
      killPulse_q <= killPulse_d;
      latch_q     <= latch_d;
    end
  end

  frame_timer #(.W(TIMER_W)) uHitTimer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timersClear),
    .load      (hitLoad),
    .tick      (hitTick),
    .loadValue (TIMER_W'(INVULN_FRAMES)),
    .active    (hitActive)
  );

  frame_timer #(.W(TIMER_W)) uGodTimer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timersClear),
    .load      (frameTick && latch_q.god),
    .tick      (frameTick),
    .loadValue (TIMER_W'(GOD_FRAMES)),
    .active    (god_active)
  );

  frame_timer #(.W(TIMER_W)) uTurboTimer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timersClear),
    .load      (frameTick && latch_q.turbo),
    .tick      (frameTick),
    .loadValue (TIMER_W'(TURBO_FRAMES)),
    .active    (turbo_active)
  );

  assign game_state       = state_q;
  assign lives            = lives_q;
  assign score            = score_q;
  assign player_hit_pulse = hitPulse_q;
  assign alien_kill_pulse = killPulse_q;
  assign player_visible   = (state_q == HIT) ? |(frameCnt_q & (8'd1 << BLINK_SHIFT)) : 1'b1;

endmodule

// File: doc/game_state_manager.md
Name: game_state_manager

Overview:
- Consumes the per-pixel collision strobes from the collision detector and turns them into game consequences: lives, score, power-up timers and overall game state.
- Raw strobes are sticky-latched across a frame and evaluated once per frame on startOfFrame. Display, sound and object logic therefore see one clean, frame-aligned event instead of many per-pixel pulses.

Parameters:
- START_LIVES, 3, lives loaded on game start (1..7)
- ALIEN_POINTS, 10, score added per alien hit
- SCORE_W, 16, score width; score saturates at all-ones
- INVULN_FRAMES, 60, frames of invulnerability after a player hit
- GOD_FRAMES, 300, god-mode duration in frames
- TURBO_FRAMES, 300, turbo duration in frames
- BLINK_SHIFT, 2, player blinks every 2^BLINK_SHIFT frames while in HIT

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- startOfFrame  in  1  one-cycle pulse per frame
- start_game  in  1  level; starts or restarts the game
- playerHitByAlienPulse  in  1  alien/player overlap
- playerHitByRocket  in  3  per alien-rocket hit on the player
- PlayerHitBy_h_Rocket  in  1  homing rocket hit the player
- alienHit  in  2  per player-rocket hit on an alien
- aliensReachedBorder  in  1  aliens reached the bottom
- TurboCollision  in  1  turbo pickup
- GodModeCollision  in  1  god-mode pickup
- aliens_cleared  in  1  level; no aliens left
- game_state  out  3  encoded state (package enum)
- lives  out  3  remaining lives
- score  out  SCORE_W  current score
- player_hit_pulse  out  1  one cycle per evaluated player hit
- alien_kill_pulse  out  1  one cycle per frame containing a kill
- god_active  out  1  god-mode timer nonzero
- turbo_active  out  1  turbo timer nonzero
- player_visible  out  1  player draw enable (blink)

Behaviour:
- **Reset values:** state IDLE; lives=0; score=0; all timers and latches 0; all pulses 0; player_visible=1.
- **Latching:** each input sets a sticky latch bit on any cycle it is high. alienHit is latched as two separate bits.
- **Evaluation cycle:** on a startOfFrame cycle, the registered latch values are evaluated. Latches then reload with that same cycle's inputs, not cleared to 0, so no event is lost. Results appear on outputs 1 cycle later; pulses are exactly 1 cycle wide.
- **player_hit:** OR of the three player-hit latch groups.
- **Kill count:** popcount of the alienHit latches (0..2).
- **Score:** score += count*ALIEN_POINTS, saturating. Scored in PLAY and HIT only.
- **alien_kill_pulse:** fires when count>0 in PLAY or HIT.
- **State IDLE:** start_game → PLAY; loads lives=START_LIVES, clears score and timers. This transition takes effect on any cycle, not only on startOfFrame.
- **State PLAY, evaluated in this priority order:**
  1. Border latch → GAME_OVER (god mode ignored; lives unchanged).
  2. player_hit && !god_active → lives−1, player_hit_pulse. If the new lives==0 → GAME_OVER; otherwise → HIT with hit_timer=INVULN_FRAMES.
  3. aliens_cleared → WIN.
- **State HIT:**
  - Player hits are ignored.
  - Border → GAME_OVER.
  - hit_timer decrements per frame; at 0 → PLAY.
  - aliens_cleared → WIN.
  - player_visible = frame_cnt[BLINK_SHIFT]; player_visible=1 in every other state.
- **States GAME_OVER / WIN:** hold score and lives. start_game → PLAY with the same reload as IDLE.
- **God mode:** GodModeCollision latch reloads god_timer=GOD_FRAMES; re-pickup restarts the full duration. The timer decrements per frame while >0. Turbo behaves identically with TURBO_FRAMES. Timers run only in PLAY/HIT and are cleared on entry to GAME_OVER/WIN.
- **Same frame, pickup and hit:** the god_active value from before the frame applies; the pickup takes effect from the next frame.
- **Reset mid-game:** returns to the reset values on the next clk edge. Reset dominates start_game.
- **frame_cnt:** free-running 8-bit counter, increments on startOfFrame.

Decomposition:
- Package game_pkg holds:
  - enum game_state_t {IDLE, PLAY, HIT, GAME_OVER, WIN}
  - lives width
  - default frame constants
- Sub-module frame_timer: loadable down-counter with load value, tick=startOfFrame and an active output. Instantiated three times: hit, god, turbo.

Test Plan:
- **Start and kill:** reset, start_game → state PLAY, lives=3, score=0. Then alienHit=2'b11 for 1 cycle mid-frame, then startOfFrame → score=20 one cycle later and alien_kill_pulse for 1 cycle.
- **Repeated hit in one frame:** playerHitByRocket=3'b010 for 5 cycles in one frame → exactly one player_hit_pulse; lives=2; state HIT; player_visible toggles; after 60 frames state PLAY.
- **God mode:** GodModeCollision, then next frame playerHitByAlienPulse → lives unchanged, no pulse. After 300 frames god_active=0; the next hit gives lives−1.
- **Last life:** lives=1 and a player hit → lives=0, GAME_OVER. start_game → PLAY, lives=3, score=0.
- **Simultaneous events:** aliensReachedBorder and aliens_cleared in the same frame → GAME_OVER. A hit and startOfFrame on the same cycle → the event is counted in the following frame.
- **Mid-game reset and saturation:** reset asserted in HIT → IDLE with lives=0 next cycle. Score preset near max (SCORE_W=4 build), kill → score saturates at 15.
